// File: rtl/obi_pkg.sv
// Shared OBI definitions for the arbiter slice.
//   OBI_AW / OBI_DW / OBI_BEW : address, data and byte-enable widths.
//   arb_state_e               : address-phase state of the arbiter.
package obi_pkg;

   localparam int OBI_AW  = 32;
   localparam int OBI_DW  = 32;
   localparam int OBI_BEW = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,   // no selection held, arbitrate freely
      ARB_HOLD = 1'b1    // req_o issued without gnt_i, selection frozen
   } arb_state_e;

endpackage

// File: rtl/obi_id_fifo.sv
// Response-ordering FIFO: records which master owns each accepted
// transaction so responses can be routed back in acceptance order.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push, push_data      : enqueue the winning master id
//   pop                  : dequeue the head (ignored when empty)
//   pop_data             : current head, valid when !empty
//   full, empty, count   : occupancy status
module obi_id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A push into a full FIFO is only accepted if a pop frees a slot.
   assign push_ok  = push & (~full | pop);
   assign pop_ok   = pop & ~empty;
   assign full     = (count_reg == CW'(DEPTH));
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign pop_data = mem[rd_ptr_reg];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Id storage needs no reset: entries are only read once written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave among NUM_M masters.
//   clk_i, rst_ni                      : clock, asynchronous active-low reset
//   m_req_i/m_addr_i/m_we_i/m_be_i/
//   m_wdata_i, m_gnt_o                 : per-master address phase
//   m_rvalid_o, m_rdata_o              : per-master response (shared data)
//   req_o/addr_o/we_o/be_o/wdata_o,
//   gnt_i                              : slave address phase
//   rvalid_i, rdata_i                  : slave response
//   err_o                              : sticky unexpected-response flag
module obi_arbiter
   import obi_pkg::*;
#(
   parameter int NUM_M   = 2,
   parameter int MAX_OUT = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_M-1:0]          m_req_i,
   output logic [NUM_M-1:0]          m_gnt_o,
   input  logic [NUM_M*OBI_AW-1:0]   m_addr_i,
   input  logic [NUM_M-1:0]          m_we_i,
   input  logic [NUM_M*OBI_BEW-1:0]  m_be_i,
   input  logic [NUM_M*OBI_DW-1:0]   m_wdata_i,
   output logic [NUM_M-1:0]          m_rvalid_o,
   output logic [OBI_DW-1:0]         m_rdata_o,
   output logic                      req_o,
   output logic [OBI_AW-1:0]         addr_o,
   output logic                      we_o,
   output logic [OBI_BEW-1:0]        be_o,
   output logic [OBI_DW-1:0]         wdata_o,
   input  logic                      gnt_i,
   input  logic                      rvalid_i,
   input  logic [OBI_DW-1:0]         rdata_i,
   output logic                      err_o
);

   localparam int IDW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int CW  = $clog2(MAX_OUT + 1);

   arb_state_e       state_reg;
   logic [IDW-1:0]   hold_sel_reg;
   logic [IDW-1:0]   last_winner_reg;
   logic             err_reg;

   logic [IDW-1:0]   winner;
   logic             any_req;
   logic [IDW-1:0]   sel;
   logic             push;
   logic             pop;
   logic [IDW-1:0]   head;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;

   logic [OBI_AW-1:0]  addr_arr  [NUM_M];
   logic [OBI_BEW-1:0] be_arr    [NUM_M];
   logic [OBI_DW-1:0]  wdata_arr [NUM_M];

   // Walk from the farthest candidate to the nearest so the master right
   // after last_winner overwrites everyone else and ends up with priority.
   always_comb begin
      logic [IDW-1:0] cand;
      winner  = last_winner_reg;
      any_req = 1'b0;
      for (int i = NUM_M; i >= 1; i--) begin
         cand = IDW'((int'(last_winner_reg) + i) % NUM_M);
         if (m_req_i[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
   end

   // Occupancy uses the registered count, so a pop in the same cycle does
   // not reopen arbitration. Reset gates req_o because it is combinational.
   assign sel   = (state_reg == ARB_HOLD) ? hold_sel_reg : winner;
   assign req_o = rst_ni & ((state_reg == ARB_HOLD) | (any_req & ~full));
   assign push  = req_o & gnt_i;
   assign pop   = rvalid_i & ~empty;

   for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
      assign addr_arr[gi]   = m_addr_i[gi*OBI_AW +: OBI_AW];
      assign be_arr[gi]     = m_be_i[gi*OBI_BEW +: OBI_BEW];
      assign wdata_arr[gi]  = m_wdata_i[gi*OBI_DW +: OBI_DW];
      assign m_gnt_o[gi]    = push & (sel == IDW'(gi));
      assign m_rvalid_o[gi] = pop & (head == IDW'(gi));
   end

   assign addr_o    = addr_arr[sel];
   assign we_o      = m_we_i[sel];
   assign be_o      = be_arr[sel];
   assign wdata_o   = wdata_arr[sel];
   assign m_rdata_o = rdata_i;
   assign err_o     = err_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg       <= ARB_IDLE;
         hold_sel_reg    <= '0;
         last_winner_reg <= IDW'(NUM_M - 1);
         err_reg         <= 1'b0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (req_o && !gnt_i) begin
                  state_reg    <= ARB_HOLD;
                  hold_sel_reg <= sel;
               end
            end
            ARB_HOLD: begin
               if (gnt_i) state_reg <= ARB_IDLE;
            end
            default: state_reg <= ARB_IDLE;
         endcase
         if (push) last_winner_reg <= sel;
         // A response with nothing in flight has no owner to route to.
         if (rvalid_i && (count == '0)) err_reg <= 1'b1;
      end
   end

   obi_id_fifo #(
      .WIDTH (IDW),
      .DEPTH (MAX_OUT),
      .CW    (CW)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push),
      .push_data (sel),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

endmodule

// File: tb/tb_obi_arbiter.sv
module tb_obi_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [1:0]  m_req_i;
   logic [1:0]  m_gnt_o;
   logic [63:0] m_addr_i;
   logic [1:0]  m_we_i;
   logic [7:0]  m_be_i;
   logic [63:0] m_wdata_i;
   logic [1:0]  m_rvalid_o;
   logic [31:0] m_rdata_o;
   logic        req_o;
   logic [31:0] addr_o;
   logic        we_o;
   logic [3:0]  be_o;
   logic [31:0] wdata_o;
   logic        gnt_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic        err_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   obi_arbiter #(.NUM_M(2), .MAX_OUT(2)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .m_req_i    (m_req_i),
      .m_gnt_o    (m_gnt_o),
      .m_addr_i   (m_addr_i),
      .m_we_i     (m_we_i),
      .m_be_i     (m_be_i),
      .m_wdata_i  (m_wdata_i),
      .m_rvalid_o (m_rvalid_o),
      .m_rdata_o  (m_rdata_o),
      .req_o      (req_o),
      .addr_o     (addr_o),
      .we_o       (we_o),
      .be_o       (be_o),
      .wdata_o    (wdata_o),
      .gnt_i      (gnt_i),
      .rvalid_i   (rvalid_i),
      .rdata_i    (rdata_i),
      .err_o      (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-12s observed %h expected %h", tag, obs, exp);
   endtask

   // Advance to 1 ns after the next rising edge (inputs change here).
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst_ni    = 1'b0;
      m_req_i   = 2'b11;
      m_addr_i  = {32'h0000_0200, 32'h0000_0100};
      m_we_i    = 2'b00;
      m_be_i    = 8'hFF;
      m_wdata_i = {32'hCAFE_0001, 32'h1234_5678};
      gnt_i     = 1'b1;
      rvalid_i  = 1'b1;
      rdata_i   = 32'h0;

      // Reset with live inputs: everything must stay quiet.
      tick();
      settle();
      chk("rst_req", {31'd0, req_o}, 32'd0);
      chk("rst_gnt", {30'd0, m_gnt_o}, 32'd0);
      chk("rst_rvalid", {30'd0, m_rvalid_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);

      // Stray response after reset sets the sticky error.
      m_req_i = 2'b00; gnt_i = 1'b0; rvalid_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();
      rvalid_i = 1'b1;
      settle();
      chk("err_rvalid", {30'd0, m_rvalid_o}, 32'd0);
      tick();
      rvalid_i = 1'b0;
      settle();
      chk("err_set", {31'd0, err_o}, 32'd1);
      tick();
      settle();
      chk("err_sticky", {31'd0, err_o}, 32'd1);
      rst_ni = 1'b0;
      settle();
      chk("err_clear", {31'd0, err_o}, 32'd0);
      tick();
      rst_ni = 1'b1;
      tick();

      // Round robin with both masters requesting, response one cycle later.
      m_req_i = 2'b11; gnt_i = 1'b1;
      settle();
      chk("rr_gnt0", {30'd0, m_gnt_o}, 32'd1);
      chk("rr_addr0", addr_o, 32'h100);
      tick();
      rvalid_i = 1'b1;
      settle();
      chk("rr_gnt1", {30'd0, m_gnt_o}, 32'd2);
      chk("rr_rv1", {30'd0, m_rvalid_o}, 32'd1);
      tick();
      settle();
      chk("rr_gnt2", {30'd0, m_gnt_o}, 32'd1);
      chk("rr_rv2", {30'd0, m_rvalid_o}, 32'd2);
      tick();
      settle();
      chk("rr_gnt3", {30'd0, m_gnt_o}, 32'd2);
      chk("rr_rv3", {30'd0, m_rvalid_o}, 32'd1);
      tick();
      m_req_i = 2'b00;
      settle();
      chk("rr_rv4", {30'd0, m_rvalid_o}, 32'd2);
      chk("rr_idle", {31'd0, req_o}, 32'd0);
      tick();
      rvalid_i = 1'b0;

      // m0 write then m1 read, data returned on the second response.
      m_req_i = 2'b01; m_we_i = 2'b01;
      settle();
      chk("wr_gnt", {30'd0, m_gnt_o}, 32'd1);
      chk("wr_we", {31'd0, we_o}, 32'd1);
      chk("wr_wdata", wdata_o, 32'h1234_5678);
      tick();
      m_req_i = 2'b10; m_we_i = 2'b00;
      settle();
      chk("rd_gnt", {30'd0, m_gnt_o}, 32'd2);
      chk("rd_we", {31'd0, we_o}, 32'd0);
      chk("rd_addr", addr_o, 32'h200);
      tick();
      m_req_i = 2'b00; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0;
      settle();
      chk("wr_rvalid", {30'd0, m_rvalid_o}, 32'd1);
      tick();
      rdata_i = 32'hDEAD_BEEF;
      settle();
      chk("rd_rvalid", {30'd0, m_rvalid_o}, 32'd2);
      chk("rd_rdata", m_rdata_o, 32'hDEAD_BEEF);
      tick();
      rvalid_i = 1'b0;

      // Address phase held while gnt_i is low, even if m0 drops its request.
      m_req_i = 2'b01; gnt_i = 1'b0;
      settle();
      chk("hold_req0", {31'd0, req_o}, 32'd1);
      chk("hold_gnt0", {30'd0, m_gnt_o}, 32'd0);
      tick();
      m_req_i = 2'b11;
      settle();
      chk("hold_addr1", addr_o, 32'h100);
      tick();
      m_req_i = 2'b10;
      settle();
      chk("hold_addr2", addr_o, 32'h100);
      chk("hold_req2", {31'd0, req_o}, 32'd1);
      tick();
      m_req_i = 2'b11; gnt_i = 1'b1;
      settle();
      chk("hold_gnt3", {30'd0, m_gnt_o}, 32'd1);
      chk("hold_addr3", addr_o, 32'h100);
      tick();
      settle();
      chk("hold_next", {30'd0, m_gnt_o}, 32'd2);
      chk("hold_naddr", addr_o, 32'h200);
      tick();
      m_req_i = 2'b00; gnt_i = 1'b0; rvalid_i = 1'b1;
      settle();
      chk("hold_rv0", {30'd0, m_rvalid_o}, 32'd1);
      tick();
      settle();
      chk("hold_rv1", {30'd0, m_rvalid_o}, 32'd2);
      tick();
      rvalid_i = 1'b0;

      // Outstanding limit: two grants, then blocked until a response clears.
      m_req_i = 2'b11; gnt_i = 1'b1;
      settle();
      chk("lim_gnt0", {30'd0, m_gnt_o}, 32'd1);
      tick();
      settle();
      chk("lim_gnt1", {30'd0, m_gnt_o}, 32'd2);
      tick();
      settle();
      chk("lim_block", {31'd0, req_o}, 32'd0);
      chk("lim_nogntp", {30'd0, m_gnt_o}, 32'd0);
      tick();
      rvalid_i = 1'b1;
      settle();
      chk("lim_samepop", {31'd0, req_o}, 32'd0);
      chk("lim_rv", {30'd0, m_rvalid_o}, 32'd1);
      tick();
      rvalid_i = 1'b0;
      m_req_i = 2'b10; gnt_i = 1'b0;
      settle();
      chk("lim_reopen", {31'd0, req_o}, 32'd1);
      chk("lim_addr", addr_o, 32'h200);
      tick();

      // Reset while m1 is held and one transaction is outstanding.
      m_req_i = 2'b11; gnt_i = 1'b1; rvalid_i = 1'b1;
      rst_ni = 1'b0;
      settle();
      chk("mid_req", {31'd0, req_o}, 32'd0);
      chk("mid_gnt", {30'd0, m_gnt_o}, 32'd0);
      chk("mid_rvalid", {30'd0, m_rvalid_o}, 32'd0);
      tick();
      m_req_i = 2'b00; gnt_i = 1'b0; rvalid_i = 1'b0;
      rst_ni = 1'b1;
      tick();
      rvalid_i = 1'b1;
      settle();
      chk("mid_discard", {30'd0, m_rvalid_o}, 32'd0);
      tick();
      rvalid_i = 1'b0;
      m_req_i = 2'b11; gnt_i = 1'b1;
      settle();
      chk("mid_first", {30'd0, m_gnt_o}, 32'd1);
      chk("mid_err", {31'd0, err_o}, 32'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/obi_arbiter.md
OBI_ARBITER -- requirements
Module: obi_arbiter

Interface
REQ-001 Parameter NUM_M, default 2, number of OBI masters sharing one OBI slave (legal 2..8).
REQ-002 Parameter MAX_OUT, default 2, maximum accepted-but-unanswered transactions (legal 1..8).
REQ-003 clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 m_req_i  input  NUM_M  per-master OBI request.
REQ-006 m_gnt_o  output  NUM_M  per-master OBI grant.
REQ-007 m_addr_i  input  NUM_M*32  per-master address; master k at bits [32k+31:32k].
REQ-008 m_we_i  input  NUM_M  per-master write enable.
REQ-009 m_be_i  input  NUM_M*4  per-master byte enables.
REQ-010 m_wdata_i  input  NUM_M*32  per-master write data.
REQ-011 m_rvalid_o  output  NUM_M  per-master response valid.
REQ-012 m_rdata_o  output  32  response data, shared by all masters.
REQ-013 req_o, addr_o[31:0], we_o, be_o[3:0], wdata_o[31:0]  output  slave-side OBI address phase.
REQ-014 gnt_i, rvalid_i, rdata_i[31:0]  input  slave-side OBI grant and response.
REQ-015 err_o  output  1  sticky flag: rvalid_i received with no transaction outstanding.

Function
REQ-016 The slave SHALL return exactly one rvalid_i per accepted transaction, reads and writes alike, in acceptance order.
REQ-017 Arbitration SHALL be round-robin: priority starts at master (last_winner+1) mod NUM_M and searches upward with wrap.
REQ-018 States: IDLE (no selection held) and HOLD (selection held, req_o high, gnt_i not yet seen).
REQ-019 In IDLE, when any m_req_i is high and the outstanding count is below MAX_OUT, the winner SHALL be selected combinationally and req_o asserted in the same cycle.
REQ-020 If req_o is high and gnt_i low, next state SHALL be HOLD with the winner registered; the address phase SHALL stay on that master until gnt_i, regardless of other requests.
REQ-021 addr_o, we_o, be_o, wdata_o SHALL be a combinational mux of the selected master's inputs; they are don't-care when req_o is low.
REQ-022 m_gnt_o[sel] SHALL equal gnt_i while req_o is high; all other m_gnt_o bits SHALL be 0.
REQ-023 On req_o && gnt_i: push sel into the ID FIFO, set last_winner=sel, return to IDLE; next arbitration may occur on the following cycle.
REQ-024 When the FIFO holds MAX_OUT entries, req_o SHALL be low in IDLE; a same-cycle pop does not unblock it.
REQ-025 On rvalid_i with a non-empty FIFO: m_rvalid_o[head]=1 for that cycle and the head is popped; m_rdata_o=rdata_i combinationally.
REQ-026 On rvalid_i with an empty FIFO: no m_rvalid_o asserted, err_o set to 1 until reset.
REQ-027 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-028 A master dropping m_req_i while in HOLD is a protocol violation; the arbiter SHALL keep req_o asserted for the held master.
REQ-029 Response latency through the arbiter SHALL be zero cycles; grant latency SHALL be zero cycles.

Reset
REQ-030 While rst_ni is low: state IDLE, last_winner=NUM_M-1 (master 0 has first priority), FIFO empty, err_o=0, req_o=0, m_gnt_o=0, m_rvalid_o=0.
REQ-031 Reset mid-transaction SHALL discard all outstanding IDs; the slave is reset by the same rst_ni.

Structure
REQ-032 OBI_AW=32, OBI_DW=32, OBI_BEW=4 SHALL live in the shared package obi_pkg.
REQ-033 The response-ordering FIFO SHALL be a sub-module obi_id_fifo (width clog2(NUM_M), depth MAX_OUT, with full, empty and count outputs).
REQ-034 Arbitration, HOLD register, and muxing SHALL reside in obi_arbiter itself.

Verification
REQ-035 m_req_i=2'b11 held, gnt_i=1, rvalid_i one cycle after each grant -> grants alternate m0,m1,m0,m1; m_rvalid_o follows the same order.
REQ-036 m0 req with addr 0x100, gnt_i low 3 cycles, m1 raises req in cycle 1 -> addr_o stays 0x100 until gnt; m1 granted the next cycle.
REQ-037 MAX_OUT=2, gnt_i=1, rvalid_i low -> two grants, then req_o low; one rvalid_i -> req_o high the following cycle.
REQ-038 m0 write, then m1 read, rvalid_i with rdata_i=0xDEADBEEF on the second response -> m_rvalid_o=01 then 10, m_rdata_o=0xDEADBEEF on the second.
REQ-039 rvalid_i pulse after reset with no request -> err_o=1 and stays set; no m_rvalid_o asserted.
REQ-040 rst_ni pulled low with 2 outstanding in HOLD -> all outputs 0 immediately; after release, master 0 wins the first arbitration.
